// File: rtl/adv7511_init_seq_if.sv
// Command/response bundle between the ADV7511 init sequencer and a byte-level I2C master.
// The sequencer is the master: it drives write commands and receives completion pulses.
interface adv7511_init_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_dev_addr, cmd_reg, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_dev_addr, cmd_reg, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack
    );
endinterface

// File: rtl/adv7511_init_seq.sv
// ADV7511 configuration sequencer: debounced hot-plug, power-up wait,
// 12-entry register table over I2C with NACK retry; video_en once fully acked.
module adv7511_init_seq #(
    parameter logic [6:0]  DEV_ADDR         = 7'h39,
    parameter int unsigned PWRUP_CYCLES     = 200000,
    parameter int unsigned DEBOUNCE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned RETRY_GAP_CYCLES = 1000
) (
    input  logic pixel_clk,
    input  logic rst_n,
    input  logic hpd_raw,
    input  logic restart,
    adv7511_init_seq_if.master bus,
    output logic busy,
    output logic done,
    output logic error,
    output logic video_en
);
    localparam int unsigned TMR_MAX =
        (PWRUP_CYCLES > RETRY_GAP_CYCLES) ? PWRUP_CYCLES : RETRY_GAP_CYCLES;
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 2);
    localparam logic [3:0] LAST_IDX = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_ISSUE, S_WAIT_RSP, S_GAP, S_DONE, S_ERROR
    } state_t;

    function automatic logic [15:0] tbl(input logic [3:0] i);
        case (i)
            4'd0:    tbl = 16'h4110;
            4'd1:    tbl = 16'h9803;
            4'd2:    tbl = 16'h9AE0;
            4'd3:    tbl = 16'h9C30;
            4'd4:    tbl = 16'h9D61;
            4'd5:    tbl = 16'hA2A4;
            4'd6:    tbl = 16'hA3A4;
            4'd7:    tbl = 16'hE0D0;
            4'd8:    tbl = 16'hF900;
            4'd9:    tbl = 16'h1501;
            4'd10:   tbl = 16'h1639;
            4'd11:   tbl = 16'hAF06;
            default: tbl = 16'h0000;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             abort_q, abort_d;
    logic             hpd_meta_q, hpd_sync_q;
    logic             hpd_stable_q, hpd_stable_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [15:0]      entry;

    // A sample that disagrees with hpd_stable counts up; agreeing again restarts.
    always_comb begin
        hpd_stable_d = hpd_stable_q;
        deb_cnt_d    = '0;
        if (hpd_sync_q != hpd_stable_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                hpd_stable_d = hpd_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rty_d   = rty_q;
        tmr_d   = tmr_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                tmr_d   = '0;
                if (hpd_stable_q) state_d = S_PWRUP;
            end
            S_PWRUP: begin
                if (!hpd_stable_q) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TMR_W'(PWRUP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                    rty_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ISSUE: begin
                // A command on the bus is always completed, even after HPD loss.
                if (!hpd_stable_q) abort_d = 1'b1;
                if (bus.cmd_ready) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (bus.rsp_valid) begin
                    if (abort_q || !hpd_stable_q) begin
                        state_d = S_IDLE;
                    end else if (!bus.rsp_nack) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            rty_d   = '0;
                            state_d = S_ISSUE;
                        end
                    end else if (rty_q == RTY_W'(MAX_RETRIES)) begin
                        state_d = S_ERROR;
                    end else begin
                        rty_d   = rty_q + 1'b1;
                        tmr_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!hpd_stable_q) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TMR_W'(RETRY_GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (!hpd_stable_q || restart) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rty_q        <= '0;
            tmr_q        <= '0;
            abort_q      <= 1'b0;
            hpd_meta_q   <= 1'b0;
            hpd_sync_q   <= 1'b0;
            hpd_stable_q <= 1'b0;
            deb_cnt_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rty_q        <= rty_d;
            tmr_q        <= tmr_d;
            abort_q      <= abort_d;
            hpd_meta_q   <= hpd_raw;
            hpd_sync_q   <= hpd_meta_q;
            hpd_stable_q <= hpd_stable_d;
            deb_cnt_q    <= deb_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        entry = (state_q == S_ISSUE) ? tbl(idx_q) : 16'h0000;
    end

    assign bus.cmd_valid    = (state_q == S_ISSUE);
    assign bus.cmd_dev_addr = DEV_ADDR;
    assign bus.cmd_reg      = entry[15:8];
    assign bus.cmd_data     = entry[7:0];

    assign busy     = (state_q == S_PWRUP) || (state_q == S_ISSUE) ||
                      (state_q == S_WAIT_RSP) || (state_q == S_GAP);
    assign done     = done_q;
    assign video_en = done_q;
    assign error    = error_q;
endmodule
